// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word loads and stores from the MEM stage into
// single-port data-memory cycles, with read-modify-write for sub-word stores.
module load_store_unit #(
  parameter int MEM_WORDS = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        stall_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [31:0] MEM_WORDS_L = 32'(MEM_WORDS);

  typedef enum logic [2:0] {IDLE, RD, WAIT, WR, RESP} state_t;

  state_t      state, state_nxt;
  logic [31:0] addr_q, wdata_q, data_q;
  logic [1:0]  size_q;
  logic        uns_q, write_q, err_q;
  logic        req_err;

  function automatic logic access_error(input logic [1:0] size, input logic [31:0] addr);
    logic bad;
    bad = (size == 2'b11)
       || (size == 2'b01 && addr[0])
       || (size == 2'b10 && addr[1:0] != 2'b00)
       || ({2'b00, addr[31:2]} >= MEM_WORDS_L);
    return bad;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] off, input logic uns);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {off, 3'b000};
    case (size)
      2'b00:   res = uns ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'b01:   res = uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: res = word;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wdata,
                                              input logic [1:0] size, input logic [1:0] off);
    logic [31:0] mask;
    case (size)
      2'b00:   mask = 32'h0000_00FF;
      2'b01:   mask = 32'h0000_FFFF;
      default: mask = 32'hFFFF_FFFF;
    endcase
    mask = mask << {off, 3'b000};
    return (word & ~mask) | ((wdata << {off, 3'b000}) & mask);
  endfunction

  assign req_err = access_error(req_size_i, req_addr_i);

  // Stage boundary: state register and latched request
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_valid_i) begin
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        size_q  <= req_size_i;
        uns_q   <= req_unsigned_i;
        write_q <= req_write_i;
        err_q   <= req_err;
        data_q  <= '0;
      end
      if (state == WAIT) begin
        data_q <= write_q ? store_merge(mem_rdata_i, wdata_q, size_q, addr_q[1:0])
                          : load_extract(mem_rdata_i, size_q, addr_q[1:0], uns_q);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid_i) begin
          if (req_err)                           state_nxt = RESP;
          else if (req_write_i && req_size_i == 2'b10) state_nxt = WR;
          else                                   state_nxt = RD;
        end
      end
      RD:      state_nxt = WAIT;
      WAIT:    state_nxt = write_q ? WR : RESP;
      WR:      state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore outputs: memory bus is driven only while an enable is high
  assign req_ready_o  = (state == IDLE);
  assign stall_o      = ~req_ready_o;
  assign mem_read_o   = (state == RD);
  assign mem_write_o  = (state == WR);
  assign mem_addr_o   = (mem_read_o || mem_write_o) ? {2'b00, addr_q[31:2]} : 32'b0;
  assign mem_wdata_o  = mem_write_o ? ((size_q == 2'b10) ? wdata_q : data_q) : 32'b0;
  assign resp_valid_o = (state == RESP);
  assign resp_err_o   = resp_valid_o && err_q;
  assign resp_rdata_o = (resp_valid_o && !write_q && !err_q) ? data_q : 32'b0;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit: a behavioural word-array model predicts
// response data, errors, latency and memory traffic for every request.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready_o, resp_valid_o, resp_err_o, stall_o, mem_read_o, mem_write_o;
  logic [31:0] resp_rdata_o, mem_addr_o, mem_wdata_o, mem_rdata;

  logic [31:0] mem     [0:31];
  logic [31:0] ref_mem [0:31];
  int unsigned n_rd = 0, n_wr = 0, n_resp = 0, n_acc = 0;
  int          errors = 0, checks = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_write_i(req_write),
    .req_size_i(req_size), .req_unsigned_i(req_unsigned), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o),
    .resp_err_o(resp_err_o), .stall_o(stall_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .mem_rdata_i(mem_rdata)
  );

  // Data memory: sync write, registered read, plus traffic counters
  always @(posedge clk) begin
    if (mem_read_o) begin
      n_rd      <= n_rd + 1;
      mem_rdata <= mem[mem_addr_o[4:0]];
    end
    if (mem_write_o) begin
      n_wr <= n_wr + 1;
      if (mem_addr_o < 32) mem[mem_addr_o[4:0]] <= mem_wdata_o;
    end
    if (resp_valid_o) n_resp <= n_resp + 1;
    if (req_valid && req_ready_o) n_acc <= n_acc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_req(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] got_rdata, output logic got_err);
    logic [31:0] wi, mask, exp_rd, w;
    int          sh, exp_lat, lat;
    logic        e, got, stall_ok, idle_ok;
    int unsigned rd0, wr0;
    wi   = addr >> 2;
    sh   = 8 * int'(addr[1:0]);
    e    = (sz == 3) || (sz == 1 && addr[0]) || (sz == 2 && addr[1:0] != 0) || (wi >= 32);
    mask = (sz == 0) ? 32'hFF : (sz == 1) ? 32'hFFFF : 32'hFFFF_FFFF;
    exp_rd = 0;
    if (!e && !wr) begin
      w = ref_mem[wi[4:0]];
      exp_rd = (w >> sh) & mask;
      if (!uns && sz == 0 && exp_rd[7])  exp_rd = exp_rd | 32'hFFFF_FF00;
      if (!uns && sz == 1 && exp_rd[15]) exp_rd = exp_rd | 32'hFFFF_0000;
    end
    exp_lat = e ? 1 : !wr ? 3 : (sz == 2) ? 2 : 4;

    @(negedge clk);
    check("ready_before", 32'(req_ready_o), 32'd1);
    rd0 = n_rd; wr0 = n_wr;
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_write = $urandom_range(0, 1); req_size = 2'($urandom);
    req_unsigned = $urandom_range(0, 1); req_addr = $urandom; req_wdata = $urandom;

    lat = 0; got = 1'b0; stall_ok = 1'b1; idle_ok = 1'b1;
    got_rdata = '0; got_err = 1'b0;
    while (lat < 10 && !got) begin
      @(negedge clk);
      lat++;
      if (!mem_read_o && !mem_write_o && (mem_addr_o != 0 || mem_wdata_o != 0)) idle_ok = 1'b0;
      if (resp_valid_o) begin
        got = 1'b1; got_rdata = resp_rdata_o; got_err = resp_err_o;
        if (!stall_o || req_ready_o) stall_ok = 1'b0;
      end else if (!stall_o || req_ready_o) stall_ok = 1'b0;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("resp_err", 32'(got_err), 32'(e));
    check("resp_rdata", got_rdata, exp_rd);
    check("mem_reads", n_rd - rd0, (e || (wr && sz == 2)) ? 32'd0 : 32'd1);
    check("mem_writes", n_wr - wr0, (!e && wr) ? 32'd1 : 32'd0);
    check("stall_busy", 32'(stall_ok), 32'd1);
    check("bus_idle_zero", 32'(idle_ok), 32'd1);

    if (!e && wr)
      ref_mem[wi[4:0]] = (ref_mem[wi[4:0]] & ~(mask << sh)) | ((wd & mask) << sh);
    @(negedge clk);
    check("ready_after", 32'(req_ready_o), 32'd1);
    if (!e) check("mem_word", mem[wi[4:0]], ref_mem[wi[4:0]]);
  endtask

  initial begin
    logic [31:0] rd, keep;
    logic        er;
    int unsigned a0, r0, w0;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 32; i++) ref_mem[i] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(req_ready_o), 32'd1);
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_resp_valid", 32'(resp_valid_o), 32'd0);
    check("rst_mem_en", {30'b0, mem_read_o, mem_write_o}, 32'd0);
    check("rst_bus", mem_addr_o | mem_wdata_o | resp_rdata_o, 32'd0);

    for (int i = 0; i < 32; i++) run_req(1'b1, 2'b10, 1'b0, 32'(i * 4), $urandom, rd, er);

    run_req(1'b1, 2'b10, 1'b0, 32'h0C, 32'h8081_82F3, rd, er);
    run_req(1'b0, 2'b00, 1'b0, 32'h0D, 32'h0, rd, er);
    check("lb_0d", rd, 32'hFFFF_FF82);
    run_req(1'b0, 2'b00, 1'b1, 32'h0D, 32'h0, rd, er);
    check("lbu_0d", rd, 32'h0000_0082);

    run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, rd, er);
    run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er);
    check("lw_10", rd, 32'hDEAD_BEEF);

    run_req(1'b1, 2'b00, 1'b0, 32'h13, 32'h0000_00AA, rd, er);
    check("sb_merge", mem[4], 32'hAAAD_BEEF);

    run_req(1'b0, 2'b01, 1'b0, 32'h0E, 32'h0, rd, er);
    check("lh_0e", rd, 32'hFFFF_8081);
    run_req(1'b0, 2'b01, 1'b0, 32'h0F, 32'h0, rd, er);
    check("lh_0f_err", 32'(er), 32'd1);

    run_req(1'b0, 2'b10, 1'b0, 32'h80, 32'h0, rd, er);
    check("lw_80_err", 32'(er), 32'd1);
    check("lw_80_rdata", rd, 32'd0);
    run_req(1'b1, 2'b11, 1'b0, 32'h08, 32'h1234_5678, rd, er);
    check("size3_err", 32'(er), 32'd1);

    // Valid held high: a load occupies IDLE,RD,WAIT,RESP so one accept per 4 edges
    @(negedge clk);
    a0 = n_acc; r0 = n_resp;
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'h10; req_unsigned = 1'b0;
    repeat (12) @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("b2b_accepts", n_acc - a0, 32'd3);
    check("b2b_resps", n_resp - r0, 32'd3);

    // Reset while the SB read data is in flight
    keep = ref_mem[4];
    @(negedge clk);
    w0 = n_wr; r0 = n_resp;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_addr = 32'h13; req_wdata = 32'h55;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_ready", 32'(req_ready_o), 32'd1);
    repeat (4) @(negedge clk);
    check("rst_mid_writes", n_wr - w0, 32'd0);
    check("rst_mid_resps", n_resp - r0, 32'd0);
    check("rst_mid_word", mem[4], keep);

    for (int i = 0; i < 80; i++)
      run_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              32'($urandom_range(0, 163)), $urandom, rd, er);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
